// File: rtl/demux1_4_stream.sv
// demux1_4_stream: steers one valid/ready beat stream into one of four registered output channels.
// The destination is sampled on a packet's first beat and held until its last beat.
module demux1_4_stream #(
    parameter int DW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic [1:0]    din_sel,
    input  logic          din_last,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [DW-1:0] dout0,
    output logic [DW-1:0] dout1,
    output logic [DW-1:0] dout2,
    output logic [DW-1:0] dout3,
    output logic          dout0_last,
    output logic          dout1_last,
    output logic          dout2_last,
    output logic          dout3_last,
    output logic          dout0_valid,
    output logic          dout1_valid,
    output logic          dout2_valid,
    output logic          dout3_valid,
    input  logic          dout0_ready,
    input  logic          dout1_ready,
    input  logic          dout2_ready,
    input  logic          dout3_ready,
    output logic          busy
);
    localparam logic IDLE = 1'b0;
    localparam logic LOCK = 1'b1;

    logic          state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [DW-1:0] data_q [4];
    logic [3:0]    last_q, valid_q, rdy, free, load;
    logic [1:0]    tgt;
    logic          acc;

    assign rdy       = {dout3_ready, dout2_ready, dout1_ready, dout0_ready};
    assign free      = ~valid_q | rdy;
    // Channel index is the bitwise inverse of the select code.
    assign tgt       = ~(state_q == LOCK ? sel_q : din_sel);
    assign din_ready = free[tgt];
    assign acc       = din_valid & din_ready;
    assign load      = acc ? 4'b0001 << tgt : 4'b0000;
    assign busy      = state_q == LOCK;

    always_comb begin
        state_d = acc ? (din_last ? IDLE : LOCK) : state_q;
        sel_d   = acc && state_q == IDLE ? din_sel : sel_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'b00;
            last_q  <= 4'b0000;
            valid_q <= 4'b0000;
            for (int i = 0; i < 4; i++) data_q[i] <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    data_q[i]  <= din;
                    last_q[i]  <= din_last;
                    valid_q[i] <= 1'b1;
                end else if (rdy[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign dout0       = data_q[0];
    assign dout1       = data_q[1];
    assign dout2       = data_q[2];
    assign dout3       = data_q[3];
    assign dout0_last  = last_q[0];
    assign dout1_last  = last_q[1];
    assign dout2_last  = last_q[2];
    assign dout3_last  = last_q[3];
    assign dout0_valid = valid_q[0];
    assign dout1_valid = valid_q[1];
    assign dout2_valid = valid_q[2];
    assign dout3_valid = valid_q[3];
endmodule

// File: tb/tb_demux1_4_stream.sv
// tb_demux1_4_stream: directed stimulus with a per-channel scoreboard and an independent output monitor.
module tb_demux1_4_stream;
    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] din = '0;
    logic [1:0]    din_sel = 2'b00;
    logic          din_last = 1'b0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic [DW-1:0] dd [4];
    logic [3:0]    dl, dv;
    logic [3:0]    rdy = 4'hF;
    logic          busy;
    logic [DW:0]   q [4][$];
    logic [DW:0]   e;
    int            errors = 0;
    int            checks = 0;
    int            st, tot;
    logic [DW-1:0] hold;

    always #5 clk = ~clk;

    demux1_4_stream #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .din(din), .din_sel(din_sel), .din_last(din_last),
        .din_valid(din_valid), .din_ready(din_ready),
        .dout0(dd[0]), .dout1(dd[1]), .dout2(dd[2]), .dout3(dd[3]),
        .dout0_last(dl[0]), .dout1_last(dl[1]), .dout2_last(dl[2]), .dout3_last(dl[3]),
        .dout0_valid(dv[0]), .dout1_valid(dv[1]), .dout2_valid(dv[2]), .dout3_valid(dv[3]),
        .dout0_ready(rdy[0]), .dout1_ready(rdy[1]), .dout2_ready(rdy[2]), .dout3_ready(rdy[3]),
        .busy(busy)
    );

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (dv[i] && rdy[i]) begin
                    if (q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat ch%0d: got data=%0d last=%0b expected none", i, dd[i], dl[i]);
                    end else begin
                        e = q[i].pop_front();
                        chk($sformatf("sb_data ch%0d", i), int'(dd[i]), int'(e[DW-1:0]));
                        chk($sformatf("sb_last ch%0d", i), int'(dl[i]), int'(e[DW]));
                    end
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic [1:0] sel, input logic last,
                        input int ch, output int stalls);
        bit done = 0;
        din = d; din_sel = sel; din_last = last; din_valid = 1'b1; stalls = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (din_ready) begin
                q[ch].push_back({last, d});
                done = 1;
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout ch%0d: got no acceptance expected acceptance within 20 cycles", ch);
        end else begin
            chk($sformatf("latency_valid ch%0d", ch), int'(dv[ch]), 1);
            chk($sformatf("latency_data ch%0d", ch), int'(dd[ch]), int'(d));
            chk($sformatf("latency_last ch%0d", ch), int'(dl[ch]), int'(last));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", int'(dv), 0);
        chk("reset_busy", int'(busy), 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        for (int s = 0; s < 4; s++) begin
            send(2'b10, 2'(s), 1'b1, 3 - s, st);
            chk("route_busy", int'(busy), 0);
        end

        hold = dd[0];
        @(posedge clk); #1;
        send(2'd1, 2'b01, 1'b0, 2, st);
        chk("lock_busy1", int'(busy), 1);
        send(2'd2, 2'b11, 1'b0, 2, st);
        chk("lock_busy2", int'(busy), 1);
        send(2'd3, 2'b11, 1'b1, 2, st);
        chk("lock_busy3", int'(busy), 0);
        chk("lock_dout0_data", int'(dd[0]), int'(hold));
        chk("lock_dout0_valid", int'(dv[0]), 0);

        rdy[1] = 1'b0;
        send(2'd1, 2'b10, 1'b1, 1, st);
        din = 2'd3; din_sel = 2'b10; din_last = 1'b1; din_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("bp_ready_low", int'(din_ready), 0);
            chk("bp_dout1_stable", int'(dd[1]), 1);
        end
        @(posedge clk); #1;
        rdy[1] = 1'b1;
        #1 chk("bp_ready_follows", int'(din_ready), 1);
        send(2'd3, 2'b10, 1'b1, 1, st);
        chk("bp_no_bubble", st, 0);

        rdy[2] = 1'b0;
        send(2'd3, 2'b01, 1'b1, 2, st);
        tot = 0;
        for (int b = 0; b < 8; b++) begin
            send(2'(b), b == 0 ? 2'b11 : 2'(b), b == 7, 0, st);
            tot += st;
            chk("tp_dout2_hold", int'(dd[2]), 3);
            chk("tp_dout2_valid", int'(dv[2]), 1);
        end
        chk("tp_stalls", tot, 0);
        rdy[2] = 1'b1;

        @(posedge clk); #1;
        send(2'd1, 2'b00, 1'b0, 3, st);
        chk("b2b_busyA", int'(busy), 1);
        send(2'd2, 2'b00, 1'b1, 3, st);
        chk("b2b_busyA_end", int'(busy), 0);
        send(2'd3, 2'b10, 1'b1, 1, st);
        chk("b2b_stallB", st, 0);
        chk("b2b_busyB", int'(busy), 0);

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("drain_empty ch%0d", i), q[i].size(), 0);

        rdy[1] = 1'b0;
        send(2'd2, 2'b10, 1'b1, 1, st);
        send(2'd1, 2'b11, 1'b0, 0, st);
        chk("pre_rst_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", int'(dv), 0);
        chk("rst_last", int'(dl), 0);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_data ch%0d", i), int'(dd[i]), 0);
        chk("rst_busy", int'(busy), 0);
        for (int i = 0; i < 4; i++) q[i].delete();
        @(negedge clk) rst = 1'b0;
        rdy[3] = 1'b1; din_sel = 2'b00; din_valid = 1'b0;
        #1 chk("post_rst_ready", int'(din_ready), 1);
        @(posedge clk); #1;
        send(2'd2, 2'b00, 1'b1, 3, st);
        chk("post_rst_busy", int'(busy), 0);
        rdy = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("final_empty ch%0d", i), q[i].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
